// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with a per-register busy scoreboard.
//
// Writes land at the rising edge. When several write ports target the same register,
// the highest port index wins. Reads see same-cycle writes through a bypass. Reads are
// either combinational or registered with a 1-cycle latency (READ_REG). The scoreboard
// marks a register busy on reservation from decode and clears it on writeback. A flush
// clears every busy bit.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-high
//   rd_en     in   per-read-port enable
//   rd_addr   in   packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data   out  packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_busy   out  per-read-port: addressed register still has a pending producer
//   wr_en     in   per-write-port enable
//   wr_addr   in   packed write addresses
//   wr_data   in   packed write data
//   rsv_en    in   reserve (mark busy) request
//   rsv_addr  in   register to reserve
//   flush     in   synchronous clear of all busy bits
//   busy_vec  out  raw scoreboard state, bit r = register r busy
module regfile_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_NUM    = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned RD_PORTS   = 2,
  parameter int unsigned WR_PORTS   = 2,
  parameter int unsigned READ_REG   = 0,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RD_PORTS-1:0]            rd_en,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [RD_PORTS-1:0]            rd_busy,
  input  logic [WR_PORTS-1:0]            wr_en,
  input  logic [WR_PORTS*ADDR_WIDTH-1:0] wr_addr,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                           rsv_en,
  input  logic [ADDR_WIDTH-1:0]          rsv_addr,
  input  logic                           flush,
  output logic [REG_NUM-1:0]             busy_vec
);

  logic [DATA_WIDTH-1:0]          mem_q [REG_NUM];
  logic [DATA_WIDTH-1:0]          mem_d [REG_NUM];
  logic [REG_NUM-1:0]             busy_q, busy_d;
  logic [WR_PORTS-1:0]            wr_ok;
  logic                           rsv_ok;
  logic [RD_PORTS*DATA_WIDTH-1:0] rd_data_c;
  logic [RD_PORTS-1:0]            rd_busy_c;

  // In range, and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) < REG_NUM) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    wr_ok = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      wr_ok[p] = wr_en[p] & addr_ok(wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  assign rsv_ok = rsv_en & addr_ok(rsv_addr);

  // Later (higher-index) ports overwrite earlier ones, giving top-port priority.
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      mem_d[r] = mem_q[r];
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_ok[p] && (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))) begin
          mem_d[r] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Priority: flush > reservation > writeback clear > hold.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < REG_NUM; r++) begin
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_ok[p] && (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))) begin
          busy_d[r] = 1'b0;
        end
      end
      if (rsv_ok && (rsv_addr == ADDR_WIDTH'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
    if (flush) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        mem_q[r] <= mem_d[r];
      end
      busy_q <= busy_d;
    end
  end

  // Read path with bypass. A bypassed read is satisfied, so it is never busy.
  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    logic                  hit;
    logic [DATA_WIDTH-1:0] byp;
    logic [DATA_WIDTH-1:0] stored;
    logic                  bsy;
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      ra     = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      hit    = 1'b0;
      byp    = '0;
      stored = '0;
      bsy    = 1'b0;
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wr_ok[p] && (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
          hit = 1'b1;
          byp = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      for (int r = 0; r < REG_NUM; r++) begin
        if (ra == ADDR_WIDTH'(r)) begin
          stored = mem_q[r];
          bsy    = busy_q[r];
        end
      end
      if (rd_en[i] && addr_ok(ra)) begin
        rd_data_c[i*DATA_WIDTH +: DATA_WIDTH] = hit ? byp : stored;
        rd_busy_c[i] = bsy & ~hit;
      end
    end
  end

  if (READ_REG != 0) begin : g_reg_read
    logic [RD_PORTS*DATA_WIDTH-1:0] rd_data_q;
    logic [RD_PORTS-1:0]            rd_busy_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q <= '0;
        rd_busy_q <= '0;
      end else begin
        rd_data_q <= rd_data_c;
        rd_busy_q <= rd_busy_c;
      end
    end

    assign rd_data = rd_data_q;
    assign rd_busy = rd_busy_q;
  end else begin : g_comb_read
    assign rd_data = rd_data_c;
    assign rd_busy = rd_busy_c;
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a combinational-read instance and a registered-read instance
// share one stimulus stream. Expected read results go into per-instance queues when
// a step is driven. The combinational queue drains mid-cycle and the registered queue
// drains after the capturing edge.
module tb_regfile_sb;
  localparam int unsigned DW = 32;
  localparam int unsigned RN = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned RP = 2;
  localparam int unsigned WP = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [RP-1:0]    rd_en;
  logic [RP*AW-1:0] rd_addr;
  logic [WP-1:0]    wr_en;
  logic [WP*AW-1:0] wr_addr;
  logic [WP*DW-1:0] wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             flush;

  logic [RP*DW-1:0] rd_data0, rd_data1;
  logic [RP-1:0]    rd_busy0, rd_busy1;
  logic [RN-1:0]    busy_vec0, busy_vec1;

  typedef struct {
    string            tag;
    logic [RP*DW-1:0] data;
    logic [RP-1:0]    busy;
  } exp_t;

  exp_t q_comb[$];
  exp_t q_reg[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  regfile_sb #(
    .DATA_WIDTH(DW), .REG_NUM(RN), .ADDR_WIDTH(AW), .RD_PORTS(RP), .WR_PORTS(WP),
    .READ_REG(0), .ZERO_REG(1)
  ) u_comb (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_busy(rd_busy0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_vec(busy_vec0)
  );

  regfile_sb #(
    .DATA_WIDTH(DW), .REG_NUM(RN), .ADDR_WIDTH(AW), .RD_PORTS(RP), .WR_PORTS(WP),
    .READ_REG(1), .ZERO_REG(1)
  ) u_reg (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_busy(rd_busy1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_vec(busy_vec1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_en = 1'b1;
    rsv_addr = a;
  endtask

  // Both instances see identical stimulus, so one expectation feeds both queues.
  task automatic expect_rd(input string tag, input logic [DW-1:0] d1, input logic [DW-1:0] d0,
                           input logic [1:0] b);
    exp_t e;
    e.tag = tag; e.data = {d1, d0}; e.busy = b;
    q_comb.push_back(e);
    q_reg.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    #1;
    while (q_comb.size() > 0) begin
      e = q_comb.pop_front();
      check({e.tag, " comb data"}, 64'(rd_data0), 64'(e.data));
      check({e.tag, " comb busy"}, 64'(rd_busy0), 64'(e.busy));
    end
    @(posedge clk);
    #1;
    while (q_reg.size() > 0) begin
      e = q_reg.pop_front();
      check({e.tag, " reg data"}, 64'(rd_data1), 64'(e.data));
      check({e.tag, " reg busy"}, 64'(rd_busy1), 64'(e.busy));
    end
  endtask

  task automatic check_bv(input string tag, input logic [RN-1:0] exp);
    check({tag, " busy_vec comb"}, 64'(busy_vec0), 64'(exp));
    check({tag, " busy_vec reg"}, 64'(busy_vec1), 64'(exp));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #22;
    check_bv("reset", '0);
    check("reset reg rd_data", 64'(rd_data1), 64'd0);
    check("reset reg rd_busy", 64'(rd_busy1), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // x5 write with bypass; x0 write ignored
    idle(); wr(0, 5'd5, 32'hDEADBEEF); wr(1, 5'd0, 32'hFFFFFFFF); rd(0, 5'd5); rd(1, 5'd0);
    expect_rd("wr x5 bypass", 32'h0, 32'hDEADBEEF, 2'b00);
    step();
    idle(); rd(0, 5'd5); rd(1, 5'd0);
    expect_rd("rd x5 x0", 32'h0, 32'hDEADBEEF, 2'b00);
    step();

    // Same-address write collision: port 1 wins. Disabled read port gives zero.
    idle(); wr(0, 5'd7, 32'h11111111); wr(1, 5'd7, 32'h22222222); rd(0, 5'd7);
    rd_addr[AW +: AW] = 5'd5;
    expect_rd("x7 collision bypass", 32'h0, 32'h22222222, 2'b00);
    step();
    idle(); rd(0, 5'd7); rd(1, 5'd7);
    expect_rd("x7 stored", 32'h22222222, 32'h22222222, 2'b00);
    step();

    idle(); wr(0, 5'd9, 32'hA5A5A5A5); rd(0, 5'd9); rd_addr[AW +: AW] = 5'd9;
    expect_rd("x9 bypass", 32'h0, 32'hA5A5A5A5, 2'b00);
    step();

    // Reserve x3: busy appears the next cycle, and a write to x3 masks rd_busy at once.
    idle(); rsv(5'd3); rd(0, 5'd3);
    expect_rd("rsv x3 same cycle", 32'h0, 32'h0, 2'b00);
    step();
    check_bv("after rsv x3", 32'h0000_0008);
    idle(); rd(0, 5'd3); rd(1, 5'd3);
    expect_rd("x3 busy", 32'h0, 32'h0, 2'b11);
    step();
    check_bv("x3 hold", 32'h0000_0008);
    idle(); wr(1, 5'd3, 32'h33); rd(0, 5'd3); rd(1, 5'd5);
    expect_rd("x3 write masks busy", 32'hDEADBEEF, 32'h33, 2'b00);
    step();
    check_bv("x3 cleared", '0);

    // A reservation beats a write-clear. Flush beats a reservation.
    idle(); rsv(5'd4); wr(0, 5'd4, 32'h44); rd(0, 5'd4);
    expect_rd("rsv+wr x4", 32'h0, 32'h44, 2'b00);
    step();
    check_bv("x4 busy", 32'h0000_0010);
    idle(); flush = 1'b1; rsv(5'd6); rd(0, 5'd4);
    expect_rd("flush cycle x4", 32'h0, 32'h44, 2'b01);
    step();
    check_bv("after flush", '0);

    // x0 can never be reserved.
    idle(); rsv(5'd0); rd(1, 5'd0);
    expect_rd("rsv x0", 32'h0, 32'h0, 2'b00);
    step();
    check_bv("x0 never busy", '0);

    // Asynchronous reset mid-cycle discards stored data, reservations and registered output.
    idle(); wr(0, 5'd10, 32'h1234); rsv(5'd10); rd(0, 5'd10);
    expect_rd("x10 bypass", 32'h0, 32'h1234, 2'b00);
    step();
    check_bv("x10 busy", 32'h0000_0400);
    idle(); rd(0, 5'd10);
    #2;
    rst = 1'b1;
    #1;
    check("async rst comb rd_data", 64'(rd_data0), 64'd0);
    check("async rst reg rd_data", 64'(rd_data1), 64'd0);
    check("async rst comb rd_busy", 64'(rd_busy0), 64'd0);
    check("async rst reg rd_busy", 64'(rd_busy1), 64'd0);
    check_bv("async rst", '0);
    @(negedge clk);
    rst = 1'b0;
    idle(); rd(0, 5'd10); rd(1, 5'd7);
    expect_rd("post-reset x10 x7", 32'h0, 32'h0, 2'b00);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
